// File: rtl/alpha_fade_sequencer.sv
// Foreground color / alpha sequencer feeding the blender: accepts fade commands
// and steps the 3-bit alpha code once every FRAME_DIV frame ticks.
module alpha_fade_sequencer #(
    parameter int FRAME_DIV = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_frame_tick,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic [1:0]  i_cmd_op,
    input  logic [2:0]  i_cmd_alpha,
    input  logic [11:0] i_cmd_color,
    input  logic        i_abort,
    output logic [11:0] o_fg_color,
    output logic [2:0]  o_fg_alpha,
    output logic        o_busy,
    output logic        o_done
);

    typedef enum logic [1:0] {IDLE, FADE_IN, FADE_OUT} state_t;

    localparam logic [7:0] CNT_LAST = 8'(FRAME_DIV - 1);

    state_t     state;
    logic [7:0] cnt;
    logic [2:0] alpha_step;
    logic       accept;
    logic       at_end;

    assign o_cmd_ready = (state == IDLE) && i_rst_n;
    assign accept      = i_cmd_valid && o_cmd_ready;

    // Endpoint test is on the stepped value, so 7+1 and 0-1 are never committed.
    always_comb begin
        alpha_step = (state == FADE_IN) ? o_fg_alpha + 3'd1 : o_fg_alpha - 3'd1;
        at_end     = (state == FADE_IN) ? (alpha_step == 3'd7) : (alpha_step == 3'd0);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            cnt        <= 8'd0;
            o_fg_alpha <= 3'd0;
            o_fg_color <= 12'h000;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        o_fg_color <= i_cmd_color;
                        cnt        <= 8'd0;
                        case (i_cmd_op)
                            2'b00: begin
                                if (o_fg_alpha == 3'd7) begin
                                    o_done <= 1'b1;
                                end else begin
                                    state  <= FADE_IN;
                                    o_busy <= 1'b1;
                                end
                            end
                            2'b01: begin
                                if (o_fg_alpha == 3'd0) begin
                                    o_done <= 1'b1;
                                end else begin
                                    state  <= FADE_OUT;
                                    o_busy <= 1'b1;
                                end
                            end
                            2'b10: begin
                                o_fg_alpha <= i_cmd_alpha;
                                o_done     <= 1'b1;
                            end
                            default: o_done <= 1'b1;
                        endcase
                    end
                end
                FADE_IN, FADE_OUT: begin
                    // Abort beats a coincident tick: no step, no done.
                    if (i_abort) begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                        cnt    <= 8'd0;
                    end else if (i_frame_tick) begin
                        if (cnt == CNT_LAST) begin
                            cnt        <= 8'd0;
                            o_fg_alpha <= alpha_step;
                            if (at_end) begin
                                state  <= IDLE;
                                o_busy <= 1'b0;
                                o_done <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
